// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor (A+B+cin or A-B-cin) with flags.
// Latency: a beat captured at clock edge N appears on the outputs after edge N+1 (two registers).
// Backpressure: holds up to two beats under out_ready=0; in_ready depends only on out_ready and state.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake (a, b, cin, sub)
//   out_valid/out_ready      result handshake (sum, cout, ovf, zero)
//   cout                     carry-out; in subtract mode 1 means "no borrow"
//   ovf                      two's complement overflow
//   zero                     sum == 0
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / 4;

  if (GROUP != 4) begin : g_bad_group
    $error("cla_adder_pipe: GROUP must be 4");
  end
  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 and >= 4");
  end

  // ---------------- operand prep and bit/group propagate-generate ----------------
  logic [WIDTH-1:0] b_eff, bit_p, bit_g;
  logic             c_eff;
  logic [NG-1:0]    grp_p, grp_g;

  always_comb begin
    // Subtraction is A + ~B + 1; a borrow-in flips that implicit +1 away.
    b_eff = sub ? ~b : b;
    c_eff = cin ^ sub;
    bit_p = a ^ b_eff;
    bit_g = a & b_eff;
    grp_p = '0;
    grp_g = '0;
    for (int k = 0; k < NG; k++) begin
      grp_p[k] = &bit_p[4*k +: 4];
      grp_g[k] = bit_g[4*k+3]
               | (bit_p[4*k+3] & bit_g[4*k+2])
               | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
               | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
    end
  end

  // ---------------- pipeline control ----------------
  logic s1_valid;
  logic s1_en, s2_en;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  // ---------------- stage 1 registers ----------------
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_c;
  logic [NG-1:0]    s1_gp, s1_gg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_c     <= 1'b0;
      s1_gp    <= '0;
      s1_gg    <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p  <= bit_p;
        s1_g  <= bit_g;
        s1_c  <= c_eff;
        s1_gp <= grp_p;
        s1_gg <= grp_g;
      end
    end
  end

  // ---------------- stage 2: lookahead carry resolution ----------------
  // grp_c[k] is the carry into group k; grp_c[NG] is the final carry-out.
  // Each group carry is built as a flat sum of products over the group P/G.
  logic [NG:0] grp_c;

  always_comb begin
    logic acc, prod;
    grp_c = '0;
    for (int k = 0; k <= NG; k++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = NG - 1; j >= 0; j--) begin
        if (j < k) begin
          acc  = acc | (prod & s1_gg[j]);
          prod = prod & s1_gp[j];
        end
      end
      grp_c[k] = acc | (prod & s1_c);
    end
  end

  // Carry into every bit, rippled only inside each 4-bit group from its group carry-in.
  logic [WIDTH-1:0] bit_c;

  always_comb begin
    logic carry;
    bit_c = '0;
    for (int k = 0; k < NG; k++) begin
      carry = grp_c[k];
      for (int i = 0; i < 4; i++) begin
        bit_c[4*k+i] = carry;
        carry = s1_g[4*k+i] | (s1_p[4*k+i] & carry);
      end
    end
  end

  logic [WIDTH-1:0] nxt_sum;
  assign nxt_sum = s1_p ^ bit_c;

  // ---------------- stage 2 registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= nxt_sum;
        cout <= grp_c[NG];
        ovf  <= bit_c[WIDTH-1] ^ grp_c[NG];
        zero <= ~|nxt_sum;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
module tb_cla_adder_pipe;

  localparam int NBEATS = 3400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  bit   rand_go;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    longint unsigned s;
    bit co;
    bit ov;
    bit z;
  } exp_t;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on w-bit operands.
  function automatic void ref_add(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit ci, input bit sb, output longint unsigned s,
                                  output bit co, output bit ov, output bit z);
    longint unsigned mask;
    longint half, sa, sbv, d, r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = longint'(a);
    sbv  = longint'(b);
    if (sa >= half)  sa  = sa - (half << 1);
    if (sbv >= half) sbv = sbv - (half << 1);
    if (!sb) begin
      d  = longint'(a) + longint'(b) + longint'(ci);
      co = ((d >> w) & 1) != 0;
      r  = sa + sbv + longint'(ci);
    end else begin
      d  = longint'(a) - longint'(b) - longint'(ci);
      co = (d >= 0);
      r  = sa - sbv - longint'(ci);
    end
    s  = longint'(d) & mask;
    ov = (r >= half) || (r < -half);
    z  = (s == 0);
  endfunction

  // ---------------- directed-test DUT (WIDTH=16) ----------------
  logic        d_in_valid, d_in_ready, d_cin, d_sub, d_out_valid, d_out_ready;
  logic        d_cout, d_ovf, d_zero;
  logic [15:0] d_a, d_b, d_sum;

  cla_adder_pipe #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .sum(d_sum), .cout(d_cout), .ovf(d_ovf), .zero(d_zero)
  );

  // ---------------- random-test DUTs, WIDTH in {4,16,32} ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 16 : 32);
    logic         iv, ir, ci, sb, ovld, ordy, co, of, zr;
    logic [W-1:0] ra, rb, rs;
    exp_t         q[$];
    int           sent;
    bit           done;

    cla_adder_pipe #(.WIDTH(W), .GROUP(4)) u (
      .clk(clk), .rst(rst),
      .in_valid(iv), .in_ready(ir),
      .a(ra), .b(rb), .cin(ci), .sub(sb),
      .out_valid(ovld), .out_ready(ordy),
      .sum(rs), .cout(co), .ovf(of), .zero(zr)
    );

    initial begin
      exp_t e;
      iv = 1'b0; ordy = 1'b0; ci = 1'b0; sb = 1'b0; ra = '0; rb = '0;
      sent = 0; done = 1'b0;
      wait (rand_go);
      for (int cyc = 0; cyc < 40000 && (sent < NBEATS || q.size() != 0); cyc++) begin
        @(negedge clk);
        if (sent < NBEATS) begin
          iv = ($urandom_range(0, 3) != 0);
          ra = W'($urandom);
          rb = W'($urandom);
          ci = 1'($urandom);
          sb = 1'($urandom);
          ordy = ($urandom_range(0, 3) != 0);
        end else begin
          iv   = 1'b0;
          ordy = 1'b1;
        end
        #1;
        if (ovld && ordy) begin
          if (q.size() == 0) begin
            chk($sformatf("w%0d_spurious_out", W), 1, 0);
          end else begin
            e = q.pop_front();
            chk($sformatf("w%0d_sum", W),  rs, e.s);
            chk($sformatf("w%0d_cout", W), co, e.co);
            chk($sformatf("w%0d_ovf", W),  of, e.ov);
            chk($sformatf("w%0d_zero", W), zr, e.z);
          end
        end
        if (iv && ir) begin
          ref_add(W, ra, rb, ci, sb, e.s, e.co, e.ov, e.z);
          q.push_back(e);
          sent++;
        end
      end
      if (sent < NBEATS || q.size() != 0)
        chk($sformatf("w%0d_rand_timeout", W), 1, 0);
      done = 1'b1;
    end
  end

  // One beat with out_ready=1; checks two-register latency and result/flags.
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input bit ci, input bit sb, input logic [15:0] es,
                         input bit ec, input bit eo, input bit ez);
    @(negedge clk);
    d_a = a; d_b = b; d_cin = ci; d_sub = sb; d_in_valid = 1'b1;
    #1 chk({tag, "_in_ready"}, d_in_ready, 1);
    @(negedge clk);
    d_in_valid = 1'b0;
    chk({tag, "_not_yet_valid"}, d_out_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, d_out_valid, 1);
    chk({tag, "_sum"},   d_sum, es);
    chk({tag, "_cout"},  d_cout, ec);
    chk({tag, "_ovf"},   d_ovf, eo);
    chk({tag, "_zero"},  d_zero, ez);
  endtask

  initial begin
    rst = 1'b1; rand_go = 1'b0;
    d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_out_valid", d_out_valid, 0);
    chk("reset_sum", d_sum, 0);
    chk("reset_flags", {d_cout, d_ovf, d_zero}, 0);
    rst = 1'b0;
    #1 chk("reset_in_ready", d_in_ready, 1);

    // Directed arithmetic corner cases.
    run_one("add_7fff_1", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
    run_one("add_ffff_1", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
    run_one("add_cin",    16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0, 0);
    run_one("sub_5_7",    16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 0);
    run_one("sub_8000_1", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);
    run_one("sub_borrow", 16'h0005, 16'h0005, 1, 1, 16'hFFFF, 0, 0, 0);

    // Backpressure: three beats offered against a stalled output.
    @(negedge clk);
    d_out_ready = 1'b0;
    d_a = 16'h0100; d_b = 16'h0001; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
    @(negedge clk);
    d_a = 16'h0200; d_b = 16'h0002;
    @(negedge clk);
    d_a = 16'h0300; d_b = 16'h0003;
    #1;
    chk("bp_in_ready_low", d_in_ready, 0);
    chk("bp_out_valid", d_out_valid, 1);
    chk("bp_sum0", d_sum, 16'h0101);
    repeat (2) @(negedge clk);
    chk("bp_still_full", d_in_ready, 0);
    chk("bp_sum_stable", d_sum, 16'h0101);
    chk("bp_valid_stable", d_out_valid, 1);
    d_out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", d_in_ready, 1);
    chk("bp_release_sum0", d_sum, 16'h0101);
    @(negedge clk);
    d_in_valid = 1'b0;
    chk("bp_valid1", d_out_valid, 1);
    chk("bp_sum1", d_sum, 16'h0202);
    @(negedge clk);
    chk("bp_valid2", d_out_valid, 1);
    chk("bp_sum2", d_sum, 16'h0303);
    @(negedge clk);
    chk("bp_drained", d_out_valid, 0);

    // Asynchronous reset with two beats in flight.
    @(negedge clk);
    d_a = 16'h1111; d_b = 16'h1111; d_in_valid = 1'b1;
    @(negedge clk);
    d_a = 16'h2222;
    @(negedge clk);
    d_in_valid = 1'b0;
    chk("arst_pre_valid", d_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", d_out_valid, 0);
    chk("arst_sum", d_sum, 0);
    chk("arst_flags", {d_cout, d_ovf, d_zero}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_in_ready", d_in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("arst_no_stale_%0d", i), d_out_valid, 0);
    end

    // Randomized traffic on all three widths.
    rand_go = 1'b1;
    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (g_rand[0].done && g_rand[1].done && g_rand[2].done) break;
    end
    if (!(g_rand[0].done && g_rand[1].done && g_rand[2].done))
      chk("rand_done", 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
